rotor_step_ctrl: RTL
====================

// Module: rotor_step_ctrl
// PURPOSE
//  Stepping controller for the three-rotor scrambler. Accepts one keystroke at a time and
//  advances the left/middle/right rotor positions (odometer stepping with notches and the
//  middle-rotor double step). Drives the 5-bit rotate offsets of the rotor datapath, then
//  presents the keystroke to the datapath once the offsets are stable.
//  Sits between the keypad/debounce front end and the rotor/reflector chain.
// PARAMETERS
//  NOTCH_L     16  left-rotor notch position (0..25)
//  NOTCH_M     4   middle-rotor notch position (0..25)
//  NOTCH_R     21  right-rotor notch position (0..25)
//  SETTLE_CYC  2   idle cycles after a step before emit (0..7); covers the combinational path
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  load       in   1  load start positions (honoured only in IDLE)
//  load_l     in   5  left start position
//  load_m     in   5  middle start position
//  load_r     in   5  right start position
//  key_valid  in   1  keystroke present
//  key_code   in   5  letter code, 1=A .. 26=Z
//  key_ready  out  1  high in IDLE; key accepted when key_valid & key_ready
//  pos_l      out  5  left rotate offset (0..25)
//  pos_m      out  5  middle rotate offset (0..25)
//  pos_r      out  5  right (fast) rotate offset (0..25)
//  enc_valid  out  1  one-cycle pulse: enc_code valid, pos_* stable for this letter
//  enc_code   out  5  accepted letter code forwarded to the rotor chain
// BEHAVIOUR
//  - Reset: state IDLE; pos_l/m/r=0; enc_valid=0; enc_code=0; key_ready=1. rst in any state
//    aborts the keystroke in flight; nothing emitted.
//  - FSM IDLE -> STEP -> SETTLE (SETTLE_CYC cycles, skipped if 0) -> EMIT -> IDLE.
//  - IDLE: load=1 writes pos_* <= load_* (values >=26 are written as 0); key_ready=1.
//    load and key_valid in same cycle: load wins, key dropped (not accepted).
//    key_valid with key_code 0 or >26: ignored, no step, stays IDLE.
//    Valid key: latch key_code into enc_code, go to STEP.
//  - STEP (1 cycle): notch tests use pre-step positions.
//    pos_r always advances; pos_m advances if pos_r==NOTCH_R or pos_m==NOTCH_M (double step);
//    pos_l advances if pos_m==NOTCH_M. Advance is +1 mod 26 (25 -> 0). load ignored.
//  - SETTLE: positions held; count SETTLE_CYC cycles.
//  - EMIT: enc_valid=1 for exactly one cycle, enc_code held; next cycle IDLE.
//  - Latency: key accepted at edge T -> positions updated at T+1 -> enc_valid high in
//    cycle T+2+SETTLE_CYC. key_ready=0 from T+1 until return to IDLE.
//    Throughput: one key per 3+SETTLE_CYC cycles.
//  - enc_code retains last value outside EMIT; consumers qualify with enc_valid.
// CONFIGURATION
//  ROTOR_STEP_COUNT_EN defined: adds output key_count [15:0]. Reset to 0; +1 in each EMIT
//    cycle; wraps 65535 -> 0; cleared by an accepted load.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 rst for 2 cycles mid-SETTLE -> pos_*=0,0,0, key_ready=1, no enc_valid pulse.
//  2 load (0,0,0), key_code=1 -> pos=(0,0,1); enc_valid in cycle T+4 with enc_code=1.
//  3 load (0,3,21), two keys -> (0,4,22) then (1,5,23) (double step).
//  4 load (0,0,25), key -> (0,0,0); load (25,4,0), key -> (0,5,1) (wrap-around).
//  5 key_code=0 and key_code=27 in IDLE -> no step, key_ready stays 1, no enc_valid.
//  6 load=1 with key_valid=1, load (3,3,3) -> pos=(3,3,3), key dropped; key_valid during
//    STEP/SETTLE ignored (key_ready=0).

Source files
------------

// File: rtl/rotor_step_ctrl.sv
// -----------------------------------------------------------------------------
// rotor_step_ctrl
//
// Stepping controller for the three-rotor scrambler. Accepts one keystroke at a
// time, advances the left/middle/right rotor positions with odometer stepping
// (notches plus the middle-rotor double step), drives the rotate offsets of the
// rotor datapath and then presents the keystroke once those offsets are stable.
//
// Sequence per keystroke: IDLE -> STEP -> SETTLE (SETTLE_CYC cycles, skipped
// when 0) -> EMIT -> IDLE, i.e. one key every 3+SETTLE_CYC cycles.
//
// Parameters
//   NOTCH_L     left-rotor notch position   (0..25)
//   NOTCH_M     middle-rotor notch position (0..25)
//   NOTCH_R     right-rotor notch position  (0..25)
//   SETTLE_CYC  idle cycles between step and emit (0..7)
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   load       in   1   load start positions (IDLE only, wins over a key)
//   load_l/m/r in   5   start positions; values >= 26 load as 0
//   key_valid  in   1   keystroke present
//   key_code   in   5   letter code 1..26; other codes are ignored
//   key_ready  out  1   high in IDLE; key taken on key_valid & key_ready
//   pos_l/m/r  out  5   rotate offsets (0..25) for the rotor datapath
//   enc_valid  out  1   one-cycle pulse, enc_code valid and pos_* stable
//   enc_code   out  5   accepted letter code (holds last value otherwise)
//   key_count  out  16  only with ROTOR_STEP_COUNT_EN defined: emitted-key
//                       count, wraps at 65535, cleared by an accepted load
//
// Optional feature macro: ROTOR_STEP_COUNT_EN
// -----------------------------------------------------------------------------
module rotor_step_ctrl #(
  parameter int unsigned NOTCH_L    = 16,
  parameter int unsigned NOTCH_M    = 4,
  parameter int unsigned NOTCH_R    = 21,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [4:0]  load_l,
  input  logic [4:0]  load_m,
  input  logic [4:0]  load_r,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        key_ready,
  output logic [4:0]  pos_l,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_r,
  output logic        enc_valid,
  output logic [4:0]  enc_code
`ifdef ROTOR_STEP_COUNT_EN
  ,
  output logic [15:0] key_count
`endif
);

  // Rotor index map used by the per-rotor generate loop.
  localparam int unsigned ROT_R = 0;
  localparam int unsigned ROT_M = 1;
  localparam int unsigned ROT_L = 2;

  localparam logic [4:0] LP_NOTCH_M = 5'(NOTCH_M);
  localparam logic [4:0] LP_NOTCH_R = 5'(NOTCH_R);

  // The left notch would only drive a fourth rotor; it is kept as a parameter
  // so the rotor set stays described in one place.
  localparam logic [4:0] LP_NOTCH_L = 5'(NOTCH_L);

  // Last SETTLE count value. Unused (and harmlessly wrapped) when SETTLE_CYC=0
  // because SETTLE is never entered in that case.
  localparam logic [2:0] LP_SETTLE_LAST = 3'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_load_accept;
  logic        w_key_accept;
  logic        w_code_ok;
  logic [2:0]  r_settle_cnt;
  logic [4:0]  r_enc_code;

  logic [4:0]  r_pos     [3];
  logic [4:0]  w_load_in [3];
  logic [4:0]  w_load_val[3];
  logic        w_adv     [3];

  // +1 modulo 26. Positions are always kept in 0..25, so >= covers 25.
  function automatic logic [4:0] f_inc26(input logic [4:0] p);
    return (p >= 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------------
  assign w_code_ok = (key_code != 5'd0) && (key_code <= 5'd26);

  always_comb begin
    w_state_next  = r_state;
    w_load_accept = 1'b0;
    w_key_accept  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // load has priority; a key presented in the same cycle is dropped.
        if (load) begin
          w_load_accept = 1'b1;
        end else if (key_valid && w_code_ok) begin
          w_key_accept = 1'b1;
          w_state_next = ST_STEP;
        end
      end
      ST_STEP: begin
        w_state_next = (SETTLE_CYC == 0) ? ST_EMIT : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == LP_SETTLE_LAST) begin
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, settle counter, latched letter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 3'd0;
      r_enc_code   <= 5'd0;
    end else begin
      r_state <= w_state_next;
      // Counter restarts on every STEP so each SETTLE begins at zero.
      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 3'd1;
      end else begin
        r_settle_cnt <= 3'd0;
      end
      if (w_key_accept) begin
        r_enc_code <= key_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rotor positions
  // ---------------------------------------------------------------------------
  assign w_load_in[ROT_R] = load_r;
  assign w_load_in[ROT_M] = load_m;
  assign w_load_in[ROT_L] = load_l;

  // Notch tests all look at the pre-step positions. The middle rotor also
  // steps when it sits on its own notch: that is the double step, which
  // happens together with the left rotor's advance.
  assign w_adv[ROT_R] = 1'b1;
  assign w_adv[ROT_M] = (r_pos[ROT_R] == LP_NOTCH_R) || (r_pos[ROT_M] == LP_NOTCH_M);
  assign w_adv[ROT_L] = (r_pos[ROT_M] == LP_NOTCH_M);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rotor
      // Out-of-range start positions are forced to 0.
      assign w_load_val[gi] = (w_load_in[gi] >= 5'd26) ? 5'd0 : w_load_in[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_pos[gi] <= 5'd0;
        end else if (w_load_accept) begin
          r_pos[gi] <= w_load_val[gi];
        end else if ((r_state == ST_STEP) && w_adv[gi]) begin
          r_pos[gi] <= f_inc26(r_pos[gi]);
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional emitted-key counter
  // ---------------------------------------------------------------------------
`ifdef ROTOR_STEP_COUNT_EN
  logic [15:0] r_key_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_count <= 16'd0;
    end else if (w_load_accept) begin
      r_key_count <= 16'd0;
    end else if (r_state == ST_EMIT) begin
      r_key_count <= r_key_count + 16'd1;
    end
  end

  assign key_count = r_key_count;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registers, so glitch-free toward the datapath)
  // ---------------------------------------------------------------------------
  assign key_ready = (r_state == ST_IDLE);
  assign enc_valid = (r_state == ST_EMIT);
  assign enc_code  = r_enc_code;
  assign pos_r     = r_pos[ROT_R];
  assign pos_m     = r_pos[ROT_M];
  assign pos_l     = r_pos[ROT_L];

  // Keeps the unused left-notch constant referenced without affecting logic.
  logic w_notch_l_unused;
  assign w_notch_l_unused = ^LP_NOTCH_L;

endmodule
